// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment driver with serial binary-to-BCD conversion.
// Defining SEG7_HEX_EN adds a hex input that loads raw nibbles and enables the A..F glyphs.
module seg7_scan_driver #(
    parameter int DIGITS        = 8,
    parameter int DATA_W        = 24,
    parameter int REFRESH_TICKS = 250000,
    parameter int LZB           = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] value,
`ifdef SEG7_HEX_EN
    input  logic              hex,
`endif
    input  logic              blank,
    output logic              busy,
    output logic              overflow,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    // The accumulator holds every decimal digit DATA_W bits can produce, and at least DIGITS.
    localparam int ACC_N  = (DATA_W / 3 + 1 > DIGITS) ? DATA_W / 3 + 1 : DIGITS;
    localparam int ACC_W  = 4 * ACC_N;
    localparam int BUF_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int TICK_W = $clog2(REFRESH_TICKS + 1);
    localparam int IDX_W  = $clog2(DIGITS + 1);

`ifdef SEG7_HEX_EN
    localparam int HEX_W = (DATA_W > BUF_W) ? DATA_W : BUF_W;
    typedef enum logic [1:0] {IDLE, SHIFT, HEX_COPY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t              state, state_next;
    logic [DATA_W-1:0]   shreg, pend_value, start_value;
    logic                pend_valid;
    logic [ACC_W-1:0]    acc, acc_adj, acc_shift;
    logic [CNT_W-1:0]    bit_cnt;
    logic [BUF_W-1:0]    disp_buf;
    logic                last_shift, start, finish_dec, pend_set;
`ifdef SEG7_HEX_EN
    logic                pend_hex, start_hex, finish_hex;
    logic [HEX_W-1:0]    hex_ext;
    assign hex_ext = HEX_W'(shreg);
`endif

    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < ACC_N; i++) begin
            acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
        end
        acc_shift = {acc_adj[ACC_W-2:0], shreg[DATA_W-1]};
    end

    assign last_shift = (bit_cnt == CNT_W'(DATA_W - 1));
    assign busy       = (state != IDLE);

    // A load arriving in the completion cycle takes precedence over the pending one.
    always_comb begin
        state_next  = state;
        start       = 1'b0;
        finish_dec  = 1'b0;
        pend_set    = 1'b0;
        start_value = load ? value : pend_value;
`ifdef SEG7_HEX_EN
        finish_hex  = 1'b0;
        start_hex   = load ? hex : pend_hex;
`endif
        case (state)
            IDLE: start = load;
            SHIFT: begin
                if (last_shift) begin
                    finish_dec = 1'b1;
                    start      = load | pend_valid;
                end else begin
                    pend_set = load;
                end
            end
`ifdef SEG7_HEX_EN
            HEX_COPY: begin
                finish_hex = 1'b1;
                start      = load | pend_valid;
            end
`endif
            default: ;
        endcase
`ifdef SEG7_HEX_EN
        if (start)
            state_next = start_hex ? HEX_COPY : SHIFT;
        else if (finish_dec || finish_hex)
            state_next = IDLE;
`else
        if (start)
            state_next = SHIFT;
        else if (finish_dec)
            state_next = IDLE;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg      <= '0;
            acc        <= '0;
            bit_cnt    <= '0;
            pend_valid <= 1'b0;
            pend_value <= '0;
            disp_buf   <= '0;
            overflow   <= 1'b0;
`ifdef SEG7_HEX_EN
            pend_hex   <= 1'b0;
`endif
        end else begin
            if (start) begin
                shreg   <= start_value;
                acc     <= '0;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                shreg   <= shreg << 1;
                acc     <= acc_shift;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_value <= value;
`ifdef SEG7_HEX_EN
                pend_hex   <= hex;
`endif
            end else if (start) begin
                pend_valid <= 1'b0;
            end
            if (finish_dec) begin
                disp_buf <= acc_shift[BUF_W-1:0];
                overflow <= |(acc_shift >> BUF_W);
            end
`ifdef SEG7_HEX_EN
            if (finish_hex) begin
                disp_buf <= hex_ext[BUF_W-1:0];
                overflow <= |(hex_ext >> BUF_W);
            end
`endif
        end
    end

    logic [TICK_W-1:0] tick_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [BUF_W-1:0]  upper;
    logic              lit;
    logic [6:0]        glyph;

    // upper holds the scanned nibble and every more significant one, which drives blanking.
    always_comb begin
        upper = disp_buf >> {scan_idx, 2'b00};
        lit   = !blank && (scan_idx == '0 || LZB == 0 || overflow || (|upper));
        glyph = 7'h7F;
        if (overflow) begin
            glyph = 7'h3F;
        end else begin
            case (upper[3:0])
                4'h0: glyph = 7'h40;
                4'h1: glyph = 7'h79;
                4'h2: glyph = 7'h24;
                4'h3: glyph = 7'h30;
                4'h4: glyph = 7'h19;
                4'h5: glyph = 7'h12;
                4'h6: glyph = 7'h02;
                4'h7: glyph = 7'h78;
                4'h8: glyph = 7'h00;
                4'h9: glyph = 7'h10;
`ifdef SEG7_HEX_EN
                4'hA: glyph = 7'h08;
                4'hB: glyph = 7'h03;
                4'hC: glyph = 7'h46;
                4'hD: glyph = 7'h21;
                4'hE: glyph = 7'h06;
                4'hF: glyph = 7'h0E;
`endif
                default: glyph = 7'h7F;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            scan_idx <= '0;
            an       <= '1;
            seg      <= 7'h7F;
        end else begin
            if (tick_cnt == TICK_W'(REFRESH_TICKS - 1)) begin
                tick_cnt <= '0;
                scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            an  <= lit ? ~(DIGITS'(1) << scan_idx) : '1;
            seg <= lit ? glyph : 7'h7F;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver (8- and 4-digit instances).
module tb_seg7_scan_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        load8, blank8, busy8, ovf8;
    logic [23:0] value8;
    logic [7:0]  an8;
    logic [6:0]  seg8;
    logic        load4, blank4, busy4, ovf4;
    logic [23:0] value4;
    logic [3:0]  an4;
    logic [6:0]  seg4;
`ifdef SEG7_HEX_EN
    logic        hex8, hex4;
`endif

    int errors = 0;
    int checks = 0;

    logic [6:0] f_seg[8];
    bit         f_lit[8];
    int         f_bad;

    always #5 clock = ~clock;

    seg7_scan_driver #(.DIGITS(8), .DATA_W(24), .REFRESH_TICKS(4), .LZB(1)) dut (
        .clock(clock), .reset(reset), .load(load8), .value(value8),
`ifdef SEG7_HEX_EN
        .hex(hex8),
`endif
        .blank(blank8), .busy(busy8), .overflow(ovf8), .an(an8), .seg(seg8)
    );

    seg7_scan_driver #(.DIGITS(4), .DATA_W(24), .REFRESH_TICKS(4), .LZB(1)) dut4 (
        .clock(clock), .reset(reset), .load(load4), .value(value4),
`ifdef SEG7_HEX_EN
        .hex(hex4),
`endif
        .blank(blank4), .busy(busy4), .overflow(ovf4), .an(an4), .seg(seg4)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Records which digits light over more than one full frame and the glyph each shows.
    task automatic capture_frame(input bit four);
        logic [7:0] a;
        logic [6:0] s;
        int nz, idx;
        f_bad = 0;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            f_lit[i] = 1'b0;
            f_seg[i] = 7'h7F;
        end
        repeat (40) begin
            tick;
            a = four ? {4'hF, an4} : an8;
            s = four ? seg4 : seg8;
            if (a === 8'hFF) begin
                if (s !== 7'h7F) f_bad++;
            end else begin
                nz = 0;
                for (int i = 0; i < 8; i++) if (a[i] === 1'b0) begin nz++; idx = i; end
                if (nz != 1) f_bad++;
                else begin
                    if (f_lit[idx] && f_seg[idx] !== s) f_bad++;
                    f_lit[idx] = 1'b1;
                    f_seg[idx] = s;
                end
            end
        end
    endtask

    task automatic load_wait(input bit four, input logic [23:0] v, output int n);
        if (four) begin load4 = 1'b1; value4 = v; end
        else      begin load8 = 1'b1; value8 = v; end
        tick;
        load4 = 1'b0;
        load8 = 1'b0;
        n = 0;
        while ((four ? busy4 : busy8) === 1'b1 && n < 200) begin
            n++;
            tick;
        end
    endtask

    task automatic sync_digit0(output bit found);
        logic [7:0] prev;
        found = 1'b0;
        prev = an8;
        for (int i = 0; i < 100 && !found; i++) begin
            tick;
            if (an8 === 8'hFE && prev !== 8'hFE) found = 1'b1;
            else prev = an8;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL sync_digit0 got no_digit0 want digit0_seen");
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load8 = 0; blank8 = 0; value8 = '0;
        load4 = 0; blank4 = 0; value4 = '0;
`ifdef SEG7_HEX_EN
        hex8 = 0; hex4 = 0;
`endif
        tick; tick;
        checks++; if (an8 !== 8'hFF)  begin errors++; $display("FAIL reset_an got %h want ff", an8); end
        checks++; if (seg8 !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy8); end
        checks++; if (ovf8 !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %b want 0", ovf8); end
        reset = 1'b0;
        tick;
        checks++; if (an8 !== 8'hFE)  begin errors++; $display("FAIL release_an got %h want fe", an8); end
        checks++; if (seg8 !== 7'h40) begin errors++; $display("FAIL release_seg got %h want 40", seg8); end
        capture_frame(1'b0);
        checks++;
        if (f_lit[1] || f_lit[2] || f_lit[3] || f_lit[4] || f_lit[5] || f_lit[6] || f_lit[7] || !f_lit[0]) begin
            errors++; $display("FAIL release_frame got lit_other want digit0_only");
        end
    endtask

    task automatic test_decimal(input string name, input bit four, input logic [23:0] v,
                                input logic exp_ovf, input logic [7:0] exp_mask, input logic [55:0] exp_segs);
        int n;
        load_wait(four, v, n);
        checks++; if (n != 24) begin errors++; $display("FAIL %s busy_cycles got %0d want 24", name, n); end
        checks++;
        if ((four ? ovf4 : ovf8) !== exp_ovf) begin
            errors++; $display("FAIL %s overflow got %b want %b", name, four ? ovf4 : ovf8, exp_ovf);
        end
        capture_frame(four);
        checks++; if (f_bad != 0) begin errors++; $display("FAIL %s frame_shape got %0d bad want 0", name, f_bad); end
        for (int i = 0; i < (four ? 4 : 8); i++) begin
            checks++;
            if (f_lit[i] !== exp_mask[i]) begin
                errors++; $display("FAIL %s lit[%0d] got %b want %b", name, i, f_lit[i], exp_mask[i]);
            end else if (exp_mask[i] && f_seg[i] !== exp_segs[7*i +: 7]) begin
                errors++; $display("FAIL %s seg[%0d] got %h want %h", name, i, f_seg[i], exp_segs[7*i +: 7]);
            end
        end
    endtask

    task automatic test_blank;
        bit found;
        sync_digit0(found);
        tick;
        blank8 = 1'b1;
        tick;
        checks++; if (an8 !== 8'hFF)  begin errors++; $display("FAIL blank_an got %h want ff", an8); end
        checks++; if (seg8 !== 7'h7F) begin errors++; $display("FAIL blank_seg got %h want 7f", seg8); end
        repeat (8) tick;
        blank8 = 1'b0;
        tick;
        checks++; if (an8 !== 8'hFB)  begin errors++; $display("FAIL unblank_an got %h want fb", an8); end
        checks++; if (seg8 !== 7'h30) begin errors++; $display("FAIL unblank_seg got %h want 30", seg8); end
        tick;
        checks++; if (an8 !== 8'hF7)  begin errors++; $display("FAIL unblank_next_an got %h want f7", an8); end
    endtask

    task automatic test_back_to_back;
        bit found;
        int nb, end_k;
        logic [7:0] exp_an;
        sync_digit0(found);
        repeat (6) tick;
        load8 = 1'b1; value8 = 24'd999;
        nb = 0; end_k = 0;
        for (int k = 1; k <= 60; k++) begin
            tick;
            if (k == 1)  load8 = 1'b0;
            if (k == 5)  begin load8 = 1'b1; value8 = 24'd42; end
            if (k == 6)  load8 = 1'b0;
            if (k == 10) begin load8 = 1'b1; value8 = 24'd77; end
            if (k == 11) load8 = 1'b0;
            if (busy8 === 1'b1) nb++;
            else if (end_k == 0) end_k = k;
            if (k >= 26 && k <= 37) begin
                exp_an = ~(8'h01 << ((k - 26) / 4));
                checks++;
                if (an8 !== exp_an || seg8 !== 7'h10) begin
                    errors++; $display("FAIL b2b_999 k=%0d got an=%h seg=%h want an=%h seg=10", k, an8, seg8, exp_an);
                end
            end else if (k >= 38 && k <= 49) begin
                checks++;
                if (an8 !== 8'hFF) begin errors++; $display("FAIL b2b_999_hi k=%0d got %h want ff", k, an8); end
            end
        end
        checks++; if (nb != 48)    begin errors++; $display("FAIL b2b_busy got %0d want 48", nb); end
        checks++; if (end_k != 49) begin errors++; $display("FAIL b2b_end got %0d want 49", end_k); end
        capture_frame(1'b0);
        checks++;
        if (f_bad != 0 || !f_lit[0] || !f_lit[1] || f_lit[2] || f_seg[0] !== 7'h78 || f_seg[1] !== 7'h78) begin
            errors++; $display("FAIL b2b_final got %h%h lit=%b%b%b want 7878 lit=110", f_seg[1], f_seg[0], f_lit[0], f_lit[1], f_lit[2]);
        end
    endtask

    task automatic test_completion_load;
        int nb, end_k;
        load8 = 1'b1; value8 = 24'd5;
        nb = 0; end_k = 0;
        for (int k = 1; k <= 60; k++) begin
            tick;
            if (k == 1)  load8 = 1'b0;
            if (k == 24) begin load8 = 1'b1; value8 = 24'd6; end
            if (k == 25) load8 = 1'b0;
            if (busy8 === 1'b1) nb++;
            else if (end_k == 0) end_k = k;
        end
        checks++; if (nb != 48)    begin errors++; $display("FAIL cmpl_busy got %0d want 48", nb); end
        checks++; if (end_k != 49) begin errors++; $display("FAIL cmpl_end got %0d want 49", end_k); end
        capture_frame(1'b0);
        checks++;
        if (!f_lit[0] || f_lit[1] || f_seg[0] !== 7'h02) begin
            errors++; $display("FAIL cmpl_frame got seg=%h lit1=%b want seg=02 lit1=0", f_seg[0], f_lit[1]);
        end
    endtask

    task automatic test_reset_busy;
        int nb;
        load8 = 1'b1; value8 = 24'd12345;
        tick;
        load8 = 1'b0;
        repeat (3) tick;
        load8 = 1'b1; value8 = 24'd999;
        tick;
        load8 = 1'b0;
        repeat (2) tick;
        reset = 1'b1;
        #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL rstbusy_busy got %b want 0", busy8); end
        checks++; if (an8 !== 8'hFF)  begin errors++; $display("FAIL rstbusy_an got %h want ff", an8); end
        checks++; if (seg8 !== 7'h7F) begin errors++; $display("FAIL rstbusy_seg got %h want 7f", seg8); end
        tick;
        reset = 1'b0;
        tick;
        checks++; if (an8 !== 8'hFE || seg8 !== 7'h40) begin
            errors++; $display("FAIL rstbusy_buf got an=%h seg=%h want an=fe seg=40", an8, seg8);
        end
        nb = 0;
        repeat (60) begin tick; if (busy8 !== 1'b0) nb++; end
        checks++; if (nb != 0) begin errors++; $display("FAIL rstbusy_pending got %0d busy want 0", nb); end
    endtask

`ifdef SEG7_HEX_EN
    task automatic test_hex;
        hex8 = 1'b1; load8 = 1'b1; value8 = 24'hAB12;
        tick;
        hex8 = 1'b0; load8 = 1'b0;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL hex_busy got %b want 1", busy8); end
        tick;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL hex_busy_end got %b want 0", busy8); end
        checks++; if (ovf8 !== 1'b0)  begin errors++; $display("FAIL hex_ovf got %b want 0", ovf8); end
        capture_frame(1'b0);
        checks++;
        if (f_seg[0] !== 7'h24 || f_seg[1] !== 7'h79 || f_seg[2] !== 7'h03 || f_seg[3] !== 7'h08 || f_lit[4]) begin
            errors++; $display("FAIL hex_frame got %h %h %h %h lit4=%b want 08 03 79 24 lit4=0",
                               f_seg[3], f_seg[2], f_seg[1], f_seg[0], f_lit[4]);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_decimal("dec_12345", 1'b0, 24'd12345, 1'b0, 8'h1F,
                     {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        test_blank;
        test_back_to_back;
        test_completion_load;
        test_decimal("dec_max8", 1'b0, 24'd16777215, 1'b0, 8'hFF,
                     {7'h79, 7'h02, 7'h78, 7'h78, 7'h78, 7'h24, 7'h79, 7'h12});
        test_decimal("dec_zeros", 1'b0, 24'd1000005, 1'b0, 8'h7F,
                     {7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12});
        test_decimal("dec_zero", 1'b0, 24'd0, 1'b0, 8'h01,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        test_decimal("d4_9999", 1'b1, 24'd9999, 1'b0, 8'h0F,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10, 7'h10, 7'h10});
        test_decimal("d4_10000", 1'b1, 24'd10000, 1'b1, 8'h0F,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
        test_decimal("d4_max", 1'b1, 24'd16777215, 1'b1, 8'h0F,
                     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
        test_reset_busy;
`ifdef SEG7_HEX_EN
        test_hex;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
